wb_project_mux: RTL

//   Parametrised Wishbone-controlled multiplexer selecting one of NCH user projects onto the

---
 rtl/wb_project_mux_if.sv | 23 ++
 rtl/wb_project_mux.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_project_mux_if.sv
// Wishbone slave bus bundle for the user-project multiplexer.
// Handshake: a transfer is requested while cyc and stb are both high; the slave
// answers with ack for exactly one clock, and read data is valid only in that clock.
interface wb_project_mux_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/wb_project_mux.sv
// Wishbone-controlled selector connecting one of NCH user projects to the pads
// and IRQ lines. Every switch drains (pads tri-stated), holds the incoming
// channel in reset, then connects it. All pad, IRQ and reset outputs are flops.
module wb_project_mux #(
    parameter int NCH     = 4,
    parameter int IO_W    = 38,
    parameter int GUARD   = 8,
    parameter int RST_CYC = 4
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_ni,
    wb_project_mux_if.slave      wbs,
    input  logic [NCH*IO_W-1:0]  ch_io_out,
    input  logic [NCH*IO_W-1:0]  ch_io_oeb,
    input  logic [NCH*3-1:0]     ch_irq,
    output logic [NCH-1:0]       ch_rst_n,
    output logic [IO_W-1:0]      io_out,
    output logic [IO_W-1:0]      io_oeb,
    output logic [2:0]           user_irq
);

    localparam int TMAX = (GUARD > RST_CYC) ? GUARD : RST_CYC;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HOLD   = 2'd2,
        ST_ACTIVE = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        cur_q, cur_d;
    logic [3:0]        req_q, req_d;
    logic              en_q, en_d;
    logic              err_q, err_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic              ack_q, ack_d;
    logic [31:0]       dat_q, dat_d;
    logic [NCH-1:0]    ch_rst_n_q, ch_rst_n_d;
    logic [IO_W-1:0]   io_out_q, io_out_d;
    logic [IO_W-1:0]   io_oeb_q, io_oeb_d;
    logic [2:0]        irq_q, irq_d;

    logic              acc;
    logic              busy;
    logic [31:0]       rdata;
    logic              unused_ok;

    // Only adr[3:2] is decoded; the remaining bus bits are intentionally ignored.
    assign unused_ok = ^{wbs.wbs_adr_i, wbs.wbs_dat_i, wbs.wbs_sel_i};

    assign busy = (state_q == ST_DRAIN) || (state_q == ST_HOLD);

    // Register file: single-cycle ack, byte-masked writes, read data captured with ack.
    always_comb begin
        acc   = wbs.wbs_cyc_i && wbs.wbs_stb_i && !ack_q;
        ack_d = acc;
        req_d = req_q;
        en_d  = en_q;
        err_d = err_q;
        dat_d = '0;
        rdata = '0;
        case (wbs.wbs_adr_i[3:2])
            2'd0: begin
                rdata[3:0] = req_q;
                rdata[31]  = en_q;
            end
            2'd1: begin
                rdata[3:0]  = cur_q;
                rdata[9:8]  = state_q;
                rdata[16]   = busy;
                rdata[24]   = err_q;
            end
            2'd2: rdata[15:0] = cnt_q;
            default: rdata = '0;
        endcase
        if (acc && !wbs.wbs_we_i) begin
            dat_d = rdata;
        end
        if (acc && wbs.wbs_we_i) begin
            case (wbs.wbs_adr_i[3:2])
                2'd0: begin
                    // An out-of-range request is refused but flagged; en in the same write still lands.
                    if (wbs.wbs_sel_i[0]) begin
                        if ({1'b0, wbs.wbs_dat_i[3:0]} < 5'(NCH)) begin
                            req_d = wbs.wbs_dat_i[3:0];
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    if (wbs.wbs_sel_i[3]) begin
                        en_d = wbs.wbs_dat_i[31];
                    end
                end
                2'd1: begin
                    if (wbs.wbs_sel_i[3] && wbs.wbs_dat_i[24]) begin
                        err_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Switch sequencer: OFF -> DRAIN -> HOLD -> ACTIVE, re-entering DRAIN on any change.
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        timer_d = timer_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_OFF: begin
                if (en_q) begin
                    state_d = ST_DRAIN;
                    timer_d = TW'(GUARD);
                end
            end
            ST_DRAIN: begin
                if (timer_q == TW'(1)) begin
                    // The request is sampled only here, so rewrites during DRAIN collapse to the last one.
                    if (en_q) begin
                        state_d = ST_HOLD;
                        cur_d   = req_q;
                        timer_d = TW'(RST_CYC);
                    end else begin
                        state_d = ST_OFF;
                        timer_d = '0;
                    end
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            ST_HOLD: begin
                if (!en_q) begin
                    state_d = ST_OFF;
                    timer_d = '0;
                end else if (timer_q == TW'(1)) begin
                    state_d = ST_ACTIVE;
                    timer_d = '0;
                    cnt_d   = cnt_q + 16'd1;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            ST_ACTIVE: begin
                if (!en_q || (req_q != cur_q)) begin
                    state_d = ST_DRAIN;
                    timer_d = TW'(GUARD);
                end
            end
            default: state_d = ST_OFF;
        endcase
    end

    // Pad/IRQ/reset outputs follow the next state so the new channel appears on the ACTIVE entry edge.
    always_comb begin
        io_out_d   = '0;
        io_oeb_d   = '1;
        irq_d      = '0;
        ch_rst_n_d = '0;
        if (state_d == ST_ACTIVE) begin
            for (int k = 0; k < NCH; k++) begin
                if (cur_d == 4'(k)) begin
                    io_out_d      = ch_io_out[k*IO_W +: IO_W];
                    io_oeb_d      = ch_io_oeb[k*IO_W +: IO_W];
                    irq_d         = ch_irq[k*3 +: 3];
                    ch_rst_n_d[k] = 1'b1;
                end
            end
        end
    end

    // State and output registers; asynchronous reset returns everything to the safe idle values.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q    <= ST_OFF;
            cur_q      <= '0;
            req_q      <= '0;
            en_q       <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
            timer_q    <= '0;
            ack_q      <= 1'b0;
            dat_q      <= '0;
            ch_rst_n_q <= '0;
            io_out_q   <= '0;
            io_oeb_q   <= '1;
            irq_q      <= '0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            req_q      <= req_d;
            en_q       <= en_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
            timer_q    <= timer_d;
            ack_q      <= ack_d;
            dat_q      <= dat_d;
            ch_rst_n_q <= ch_rst_n_d;
            io_out_q   <= io_out_d;
            io_oeb_q   <= io_oeb_d;
            irq_q      <= irq_d;
        end
    end

    assign wbs.wbs_ack_o = ack_q;
    assign wbs.wbs_dat_o = dat_q;
    assign ch_rst_n      = ch_rst_n_q;
    assign io_out        = io_out_q;
    assign io_oeb        = io_oeb_q;
    assign user_irq      = irq_q;

endmodule
